disp_vramrd_mo: RTL and testbench
=================================

Name: disp_vramrd_mo

Overview:
- Next-generation VRAM read master for the display path: fetches one full frame from VRAM over AXI4 read bursts per vertical start, with multiple outstanding bursts.
- Issue is gated by a beat-level credit from the display line buffer (free-space count) rather than a single ready bit.
- Sits between the display register block (DISPADDR/DISPON/RESOL), the syncgen (VRSTART) and the VRAM read port. RDATA goes straight to the buffer and does not pass through this block.

Parameters:
- DATA_W, 64: AXI read data width in bits; bytes per beat = DATA_W/8.
- BURST_LEN, 32: beats per burst, 1..256. ARLEN = BURST_LEN-1.
- MAX_OUTST, 4: maximum AR issued without a matching RLAST, 1..15.
- FREE_W, 10: width of BUF_FREE.

Ports:
- ACLK  in  1  clock.
- ARST  in  1  reset. Asynchronous, active-low.
- ARADDR  out  32  burst start byte address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARSIZE  out  3  constant log2(DATA_W/8).
- ARBURST  out  2  constant 2'b01 (INCR).
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- RVALID  in  1  read data valid.
- RLAST  in  1  last beat of burst.
- RRESP  in  2  read response; used only with the optional feature.
- RREADY  out  1  read data accept.
- RESOL  in  2  resolution: 0=640x480, 1=800x600, 2=1280x1024, 3 treated as 0.
- VRSTART  in  1  frame start level from syncgen (foreign domain).
- DISPON  in  1  display enable.
- DISPADDR  in  29  frame base byte address, zero-extended; must be burst-aligned.
- BUF_FREE  in  FREE_W  free beat slots in the line buffer.
- BUSY  out  1  frame fetch or drain in progress.
- FRAME_DONE  out  1  one-cycle pulse when the last burst of a frame completes.

Behaviour:
- Reset (ARST=0, asynchronous) clears everything:
  - state IDLE; ARVALID=0, RREADY=0, BUSY=0, FRAME_DONE=0;
  - offset=0, outstanding=0, VRSTART sync flops=0.
- VRSTART handling:
  - Passes through a 2-FF synchronizer, then a rising-edge detector (third flop).
  - start_evt = synced rising edge AND DISPON.
- Frame start: on start_evt in IDLE, latch base={3'b0,DISPADDR}, latch total bursts from RESOL, clear offset, go to RUN.
- Total bursts = H*V*4/(BURST_LEN*DATA_W/8). At defaults: 4800, 7500, 20480. Bursts-issued counter is 16 bits.
- ARADDR = base + offset. offset advances by BURST_LEN*DATA_W/8 on each AR handshake.
- AR issue rule:
  - In RUN, raise ARVALID when all hold: issued<total, outstanding<MAX_OUTST, and BUF_FREE >= (outstanding+1)*BURST_LEN.
  - Once raised, ARVALID and ARADDR are held stable until ARREADY, regardless of credit or DISPON.
  - Address handshake takes effect on the cycle where ARVALID&&ARREADY.
- Outstanding counter:
  - +1 on AR handshake; -1 on an R handshake with RLAST.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST and never underflows. An RLAST arriving with outstanding=0 is ignored.
- RREADY = (outstanding != 0), registered from the counter. Buffer space is already reserved, so no backpressure is applied.
- State machine: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start_evt.
  - RUN -> DRAIN when issued==total and no AR is pending.
  - RUN -> DRAIN when DISPON falls (finish any pending AR first).
  - RUN -> DRAIN on a new start_evt (pending AR completes; restart flag set).
  - DRAIN -> IDLE when outstanding==0.
  - On that DRAIN exit: FRAME_DONE pulses for 1 cycle only if issued==total. If the restart flag is set, the new frame is started in the same cycle (latch and go to RUN).
- start_evt arriving in DRAIN sets the restart flag; multiple events collapse into one.
- BUSY = state != IDLE.

Optional Feature:
- Macro: DISP_VRAMRD_ERRCAP_EN.
- Defined:
  - Adds outputs RERR (1) and RERR_ADDR (32).
  - On the first R handshake with RRESP != 2'b00 since frame start, latch RERR=1 and RERR_ADDR = start address of the burst being returned.
  - Requires a MAX_OUTST-deep address FIFO.
  - Both outputs are cleared at the next frame start and by reset.
  - Fetch continues normally after an error.
- Undefined: RRESP is unused; no FIFO and no extra ports.

Test Plan:
- RESOL=0, DISPADDR=0x1000_0000, BUF_FREE=1023, ARREADY=1, slave returns 32-beat bursts -> exactly 4800 AR handshakes.
  - Addresses run 0x1000_0000..0x1012_BF00 in 0x100 steps.
  - outstanding peaks at 4; FRAME_DONE is one pulse after the 4800th RLAST; BUSY then drops.
- BUF_FREE=64, slave holds RVALID low -> at most 2 AR issued. ARVALID stays low until BUF_FREE rises to ≥96.
- ARREADY held low 10 cycles while BUF_FREE drops to 0 -> ARVALID and ARADDR remain stable throughout; handshake completes when ARREADY rises.
- DISPON cleared after 100 bursts -> no new AR after the pending one; RREADY stays high until the last RLAST; IDLE with FRAME_DONE never asserted.
- Second VRSTART rising edge mid-frame at RESOL=2 -> drain, then the restart begins at DISPADDR with offset 0; next frame issues 20480 bursts.
- With DISP_VRAMRD_ERRCAP_EN: RRESP=2'b10 on the 3rd burst (base 0) -> RERR=1, RERR_ADDR=0x200; cleared at the next frame start.

Source files
------------

// File: rtl/disp_vramrd_mo.sv
// disp_vramrd_mo: AXI4 VRAM frame read master, credit-gated issue with multiple outstanding bursts.
// Define DISP_VRAMRD_ERRCAP_EN to add RRESP error capture (RERR/RERR_ADDR).
module disp_vramrd_mo #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 32,
    parameter int MAX_OUTST = 4,
    parameter int FREE_W    = 10
) (
    input  logic              ACLK,
    input  logic              ARST,
    output logic [31:0]       ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic              RVALID,
    input  logic              RLAST,
    input  logic [1:0]        RRESP,
    output logic              RREADY,
    input  logic [1:0]        RESOL,
    input  logic              VRSTART,
    input  logic              DISPON,
    input  logic [28:0]       DISPADDR,
    input  logic [FREE_W-1:0] BUF_FREE,
    output logic              BUSY,
`ifdef DISP_VRAMRD_ERRCAP_EN
    output logic              RERR,
    output logic [31:0]       RERR_ADDR,
`endif
    output logic              FRAME_DONE
);
    localparam int BPB = BURST_LEN * DATA_W / 8;
    localparam int T0  = 640 * 480 * 4 / BPB;
    localparam int T1  = 800 * 600 * 4 / BPB;
    localparam int T2  = 1280 * 1024 * 4 / BPB;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic [2:0]  vs_q;
    logic [31:0] base, offset;
    logic [15:0] issued, total, issued_nxt;
    logic [3:0]  outst, outst_nxt;
    logic        restart, start_evt, ar_hs, r_last, ar_done, credit_ok, can_issue, frame_start;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'($clog2(DATA_W / 8));
    assign ARBURST = 2'b01;
    assign BUSY    = state != IDLE;

    assign start_evt  = vs_q[1] & ~vs_q[2] & DISPON;
    assign ar_hs      = ARVALID & ARREADY;
    assign r_last     = RVALID & RREADY & RLAST & (outst != 4'd0);
    assign ar_done    = !ARVALID || ARREADY;
    assign issued_nxt = issued + {15'd0, ar_hs};
    assign outst_nxt  = outst + {3'd0, ar_hs} - {3'd0, r_last};
    assign credit_ok  = {{(32-FREE_W){1'b0}}, BUF_FREE} >= ({28'd0, outst} + 32'd1) * 32'(BURST_LEN);
    assign can_issue  = state == RUN && !ARVALID && !restart && !start_evt && DISPON &&
                        issued < total && outst < 4'(MAX_OUTST) && credit_ok;
    // A restart pending at drain exit launches the next frame without passing through IDLE
    assign frame_start = (state == IDLE && start_evt) ||
                         (state == DRAIN && outst == 4'd0 && (restart || start_evt));

    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            state      <= IDLE;
            vs_q       <= '0;
            base       <= '0;
            offset     <= '0;
            issued     <= '0;
            total      <= '0;
            outst      <= '0;
            restart    <= 1'b0;
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            RREADY     <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            vs_q       <= {vs_q[1:0], VRSTART};
            outst      <= outst_nxt;
            RREADY     <= outst_nxt != 4'd0;
            FRAME_DONE <= 1'b0;
            if (ar_hs) begin
                ARVALID <= 1'b0;
                issued  <= issued_nxt;
                offset  <= offset + 32'(BPB);
            end
            if (can_issue) begin
                ARVALID <= 1'b1;
                ARADDR  <= base + offset;
            end
            case (state)
                RUN: begin
                    if (start_evt) restart <= 1'b1;
                    if (ar_done && (issued_nxt == total || !DISPON || restart || start_evt)) state <= DRAIN;
                end
                DRAIN: begin
                    if (start_evt) restart <= 1'b1;
                    if (outst == 4'd0) begin
                        FRAME_DONE <= issued == total;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase
            if (frame_start) begin
                state   <= RUN;
                restart <= 1'b0;
                base    <= {3'b0, DISPADDR};
                offset  <= '0;
                issued  <= '0;
                total   <= RESOL == 2'd1 ? 16'(T1) : RESOL == 2'd2 ? 16'(T2) : 16'(T0);
            end
        end
    end

`ifdef DISP_VRAMRD_ERRCAP_EN
    localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;

    // Start addresses of bursts in flight, returned in issue order
    logic [31:0]   afifo [MAX_OUTST];
    logic [PW-1:0] wp, rp;

    always_ff @(posedge ACLK) begin
        if (ar_hs) afifo[wp] <= ARADDR;
    end

    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            wp        <= '0;
            rp        <= '0;
            RERR      <= 1'b0;
            RERR_ADDR <= '0;
        end else begin
            if (ar_hs) wp <= wp == PW'(MAX_OUTST - 1) ? '0 : wp + 1'b1;
            if (r_last) rp <= rp == PW'(MAX_OUTST - 1) ? '0 : rp + 1'b1;
            if (frame_start) begin
                RERR      <= 1'b0;
                RERR_ADDR <= '0;
            end else if (RVALID && RREADY && RRESP != 2'b00 && !RERR) begin
                RERR      <= 1'b1;
                RERR_ADDR <= afifo[rp];
            end
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^RRESP;
`endif
endmodule

// File: tb/tb_disp_vramrd_mo.sv
// tb_disp_vramrd_mo: randomized AXI slave, address scoreboard and protocol monitor for disp_vramrd_mo.
module tb_disp_vramrd_mo;
    localparam int DW = 512, BL = 16, MO = 4, FW = 10, BPB = BL * DW / 8;

    logic ACLK = 1'b0, ARST = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST, RRESP = 2'b00, RESOL = 2'd0;
    logic        ARVALID, ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0, RREADY;
    logic        VRSTART = 1'b0, DISPON = 1'b0, BUSY, FRAME_DONE;
    logic [28:0] DISPADDR = '0;
    logic [FW-1:0] BUF_FREE = '0;
`ifdef DISP_VRAMRD_ERRCAP_EN
    logic        RERR;
    logic [31:0] RERR_ADDR;
`endif

    disp_vramrd_mo #(.DATA_W(DW), .BURST_LEN(BL), .MAX_OUTST(MO), .FREE_W(FW)) dut (
        .ACLK(ACLK), .ARST(ARST), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RVALID(RVALID),
        .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY), .RESOL(RESOL), .VRSTART(VRSTART),
        .DISPON(DISPON), .DISPADDR(DISPADDR), .BUF_FREE(BUF_FREE), .BUSY(BUSY),
`ifdef DISP_VRAMRD_ERRCAP_EN
        .RERR(RERR), .RERR_ADDR(RERR_ADDR),
`endif
        .FRAME_DONE(FRAME_DONE)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen at %0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // Reference model: a frame is the list base + k*BPB for k < H*V*4/BPB
    logic [31:0] exp_q[$], next_q[$];
    bit  next_pend = 0;
    int  m_outst = 0, max_outst = 0, ar_cnt = 0, done_cnt = 0;

    function automatic int frame_total(input logic [1:0] r);
        int h, v;
        h = r == 2'd1 ? 800 : r == 2'd2 ? 1280 : 640;
        v = r == 2'd1 ? 600 : r == 2'd2 ? 1024 : 480;
        return h * v * 4 / BPB;
    endfunction

    task automatic start_frame(input logic [28:0] a, input logic [1:0] r);
        DISPADDR = a;
        RESOL = r;
        next_q.delete();
        for (int k = 0; k < frame_total(r); k++) next_q.push_back({3'b0, a} + 32'(k * BPB));
        next_pend = 1;
        VRSTART = 1'b1;
        tick(4);
        VRSTART = 1'b0;
        tick(3);
    endtask

    // Monitor: all handshakes are evaluated at the negedge preceding the edge that takes them
    logic        p_arv = 0, p_arr = 0, p_done = 0;
    logic [31:0] p_addr = 0;
    int          p_free = 0, p_outst = 0;

    always @(negedge ACLK) if (ARST) begin
        chk("rready", RREADY, m_outst != 0);
        if (p_arv && !p_arr) begin
            chk("arvalid_hold", ARVALID, 1);
            chk("araddr_hold", ARADDR, p_addr);
        end
        if (ARVALID && !p_arv) chk("credit_rule", p_free >= (p_outst + 1) * BL && p_outst < MO, 1);
        if (FRAME_DONE) begin
            done_cnt++;
            chk("done_all_issued", exp_q.size(), 0);
            chk("done_drained", m_outst, 0);
            chk("done_pulse", p_done, 0);
        end
        p_arv = ARVALID; p_arr = ARREADY; p_addr = ARADDR; p_done = FRAME_DONE;
        p_free = int'(BUF_FREE); p_outst = m_outst;
        if (RVALID && RREADY && RLAST && m_outst > 0) m_outst--;
        if (ARVALID && ARREADY) begin
            if (next_pend && (exp_q.size() == 0 || ARADDR != exp_q[0])) begin
                chk("restart_drained", m_outst, 0);
                exp_q = next_q;
                next_pend = 0;
            end
            if (exp_q.size() == 0) fail("ar_expected");
            else chk("araddr", ARADDR, exp_q.pop_front());
            chk("arlen", ARLEN, BL - 1);
            chk("arsize", ARSIZE, 6);
            chk("arburst", ARBURST, 1);
            m_outst++;
            ar_cnt++;
            if (m_outst > max_outst) max_outst = m_outst;
            if (m_outst > MO) chk("outst_max", m_outst, MO);
        end
    end

    // AXI read slave: random ARREADY/RVALID, bursts of BL beats returned in order
    int pend = 0, beat = 0, rb = 0, err_burst = -1, ar_mode = 1;
    bit r_en = 1;

    initial forever begin
        bit a, r;
        @(negedge ACLK);
        a = ARVALID && ARREADY;
        r = RVALID && RREADY;
        @(posedge ACLK);
        #1;
        if (a) pend++;
        if (r) begin
            if (RLAST) begin pend--; beat = 0; rb++; end
            else beat++;
        end
        if (!RVALID || r) begin
            RVALID = r_en && pend > 0 && $urandom_range(7) != 0;
            RLAST  = beat == BL - 1;
            RRESP  = rb == err_burst ? 2'b10 : 2'b00;
        end
        ARREADY = ar_mode == 1 ? 1'b1 : ar_mode == 2 ? 1'b0 : 1'($urandom_range(1));
    end

    task automatic wait_done(input int d0, input int lim, input string name);
        int i;
        for (i = 0; i < lim && done_cnt == d0; i++) tick(1);
        if (done_cnt == d0) fail(name);
        tick(2);
    endtask

    task automatic wait_idle(input int lim, input string name);
        int i;
        tick(2);
        for (i = 0; i < lim && BUSY; i++) tick(1);
        if (BUSY) fail(name);
    endtask

    task automatic wait_ars(input int n, input int lim, input string name);
        int i;
        for (i = 0; i < lim && ar_cnt < n; i++) tick(1);
        if (ar_cnt < n) fail(name);
    endtask

    initial begin
        int d0, c;
        tick(3);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", FRAME_DONE, 0);
        ARST = 1'b1;
        DISPON = 1'b1;
        BUF_FREE = 10'd1023;
        tick(3);
        // Full frame at 640x480
        d0 = done_cnt; ar_cnt = 0; max_outst = 0;
        start_frame(29'h1000_0000, 2'd0);
        wait_done(d0, 60000, "frame0_done");
        chk("frame0_ars", ar_cnt, 1200);
        chk("frame0_peak", max_outst, MO);
        chk("frame0_dones", done_cnt, d0 + 1);
        chk("frame0_busy", BUSY, 0);
        // Credit gating: room for two bursts only while data is held back
        BUF_FREE = 10'd32; r_en = 0; ar_cnt = 0; d0 = done_cnt;
        start_frame(29'h0200_0000, 2'd1);
        tick(60);
        chk("credit2_ars", ar_cnt, 2);
        chk("credit2_arvalid", ARVALID, 0);
        BUF_FREE = 10'd47;
        tick(20);
        chk("credit47_ars", ar_cnt, 2);
        BUF_FREE = 10'd48;
        tick(20);
        chk("credit48_ars", ar_cnt, 3);
        DISPON = 1'b0; r_en = 1; BUF_FREE = 10'd1023;
        wait_idle(2000, "credit_idle");
        chk("credit_final_ars", ar_cnt, 3);
        chk("credit_no_done", done_cnt, d0);
        exp_q.delete();
        DISPON = 1'b1;
        tick(3);
        // ARREADY stall with credit collapsing, then DISPON drop mid-frame
        ar_mode = 2; ar_cnt = 0; d0 = done_cnt;
        start_frame(29'h0400_0000, 2'd2);
        for (int i = 0; i < 20 && !ARVALID; i++) tick(1);
        chk("stall_arvalid", ARVALID, 1);
        chk("stall_araddr", ARADDR, 32'h0400_0000);
        BUF_FREE = 10'd0;
        tick(10);
        chk("stall_arvalid_held", ARVALID, 1);
        chk("stall_araddr_held", ARADDR, 32'h0400_0000);
        ar_mode = 1;
        tick(3);
        chk("stall_hs", ar_cnt, 1);
        BUF_FREE = 10'd1023; ar_mode = 0;
        wait_ars(100, 20000, "dispon_ars");
        DISPON = 1'b0;
        c = ar_cnt;
        wait_idle(5000, "dispon_idle");
        chk("dispon_no_new_ar", ar_cnt <= c + 1, 1);
        chk("dispon_no_done", done_cnt, d0);
        exp_q.delete();
        DISPON = 1'b1;
        tick(3);
        // Restart mid-frame: second VRSTART while fetching, new frame from new base
        ar_cnt = 0;
        start_frame(29'h0600_0000, 2'd2);
        wait_ars(50, 20000, "restart_ars");
        d0 = done_cnt;
        start_frame(29'h0800_0000, 2'd0);
        wait_done(d0, 60000, "restart_done");
        chk("restart_dones", done_cnt, d0 + 1);
        chk("restart_pending", next_pend, 0);
        chk("restart_busy", BUSY, 0);
`ifdef DISP_VRAMRD_ERRCAP_EN
        // Error response on third burst of a frame based at 0
        err_burst = rb + 2; ar_cnt = 0;
        start_frame(29'h0, 2'd0);
        wait_ars(10, 5000, "err_ars");
        tick(80);
        chk("rerr", RERR, 1);
        chk("rerr_addr", RERR_ADDR, 32'(2 * BPB));
        DISPON = 1'b0;
        wait_idle(5000, "err_idle");
        chk("rerr_kept", RERR, 1);
        err_burst = -1;
        exp_q.delete();
        DISPON = 1'b1;
        start_frame(29'h0A00_0000, 2'd0);
        chk("rerr_clear", RERR, 0);
        chk("rerr_addr_clear", RERR_ADDR, 0);
        DISPON = 1'b0;
        wait_idle(5000, "err2_idle");
        exp_q.delete();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
